// File: rtl/arithmetic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arithmetic_pkg
//  Purpose  : Opcode encoding and default datapath width for arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
package arithmetic_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

endpackage : arithmetic_pkg
`default_nettype wire

// File: rtl/arithmetic_div.sv
`default_nettype none
// ============================================================================
//  Module   : arithmetic_div
//  Purpose  : Iterative restoring divider, one quotient bit per clock.
//  Revision : 1.0  initial release
// ============================================================================
module arithmetic_div
    import arithmetic_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int               c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(1);

    logic               busy_q, busy_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;

    logic [WIDTH:0]     w_shifted;
    logic [WIDTH-1:0]   w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quo;

    // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
    always_comb begin
        w_shifted  = {rem_q, quo_q[WIDTH-1]};
        w_fits     = (w_shifted >= {1'b0, dsr_q});
        w_trial    = w_shifted[WIDTH-1:0] - dsr_q;
        w_step_rem = w_fits ? w_trial : w_shifted[WIDTH-1:0];
        w_step_quo = {quo_q[WIDTH-2:0], w_fits};
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = c_iters;
            rem_d  = '0;
            quo_d  = dividend;
            dsr_d  = divisor;
        end else if (busy_q) begin
            rem_d = w_step_rem;
            quo_d = w_step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == c_last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
        end
    end

    // done/quotient reflect the final iteration so the parent can register them on that edge.
    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == c_last);
    assign quotient = w_step_quo;

endmodule : arithmetic_div
`default_nettype wire

// File: rtl/arithmetic.sv
`default_nettype none
// ============================================================================
//  Module   : arithmetic
//  Purpose  : Add/sub/mul in one cycle, iterative divide, registered outputs.
//  Revision : 1.0  initial release
// ============================================================================
module arithmetic
    import arithmetic_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero
);

    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               div_by_zero_q, div_by_zero_d;

    op_e                w_op;
    logic               w_accept;
    logic               w_div_start;
    logic               w_div_busy;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quotient;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_op        = op_e'(sel);
        w_accept    = in_valid && !w_div_busy;
        w_div_start = w_accept && (w_op == OP_DIV) && (b != '0);
        w_sum       = {1'b0, a} + {1'b0, b};
        w_diff      = a - b;
        w_prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    always_comb begin
        result_d      = result_q;
        carry_d       = carry_q;
        overflow_d    = overflow_q;
        div_by_zero_d = div_by_zero_q;
        out_valid_d   = 1'b0;

        if (w_accept) begin
            carry_d       = 1'b0;
            overflow_d    = 1'b0;
            div_by_zero_d = 1'b0;
            out_valid_d   = 1'b1;
            case (w_op)
                OP_ADD: begin
                    result_d = w_sum[WIDTH-1:0];
                    carry_d  = w_sum[WIDTH];
                end
                OP_SUB: begin
                    result_d = w_diff;
                    carry_d  = (a < b);
                end
                OP_MUL: begin
                    result_d   = w_prod[WIDTH-1:0];
                    overflow_d = (w_prod[2*WIDTH-1:WIDTH] != '0);
                end
                OP_DIV: begin
                    // Non-zero divisor: result and flags wait for the divider.
                    if (b == '0) begin
                        result_d      = '1;
                        div_by_zero_d = 1'b1;
                    end else begin
                        result_d      = result_q;
                        carry_d       = carry_q;
                        overflow_d    = overflow_q;
                        div_by_zero_d = div_by_zero_q;
                        out_valid_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (w_div_done) begin
            result_d      = w_div_quotient;
            carry_d       = 1'b0;
            overflow_d    = 1'b0;
            div_by_zero_d = 1'b0;
            out_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q      <= '0;
            out_valid_q   <= 1'b0;
            carry_q       <= 1'b0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            result_q      <= result_d;
            out_valid_q   <= out_valid_d;
            carry_q       <= carry_d;
            overflow_q    <= overflow_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    arithmetic_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_div_quotient)
    );

    assign busy        = w_div_busy;
    assign result      = result_q;
    assign out_valid   = out_valid_q;
    assign carry       = carry_q;
    assign overflow    = overflow_q;
    assign div_by_zero = div_by_zero_q;

endmodule : arithmetic
`default_nettype wire

// File: tb/tb_arithmetic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arithmetic
//  Purpose  : Directed self-checking bench for arithmetic (WIDTH = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_arithmetic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic [1:0] sel;
    logic       in_valid;
    logic       busy, out_valid, carry, overflow, div_by_zero;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    arithmetic #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .sel         (sel),
        .in_valid    (in_valid),
        .busy        (busy),
        .result      (result),
        .out_valid   (out_valid),
        .carry       (carry),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Observed vector: {out_valid, busy, carry, overflow, div_by_zero, result}
    function automatic logic [12:0] obs();
        return {out_valid, busy, carry, overflow, div_by_zero, result};
    endfunction

    function automatic logic [12:0] vec(input logic v, input logic bz, input logic c,
                                        input logic o, input logic z, input logic [7:0] r);
        return {v, bz, c, o, z, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] isel);
        a = ia; b = ib; sel = isel; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h55; b = 8'h00; sel = 2'd3;
        step(); step();
        checks++;
        if (obs() !== vec(0, 0, 0, 0, 0, 8'h00))
            begin errors++; $display("FAIL reset_state got %h exp %h", obs(), vec(0,0,0,0,0,8'h00)); end
        in_valid = 1'b0; rst_n = 1'b1;
        step();
        checks++;
        if (obs() !== vec(0, 0, 0, 0, 0, 8'h00))
            begin errors++; $display("FAIL reset_idle got %h exp %h", obs(), vec(0,0,0,0,0,8'h00)); end
    endtask

    task automatic test_add();
        issue(8'd1, 8'd1, 2'd0);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'h02))
            begin errors++; $display("FAIL add_1_1 got %h exp %h", obs(), vec(1,0,0,0,0,8'h02)); end
        step();
        checks++;
        if (obs() !== vec(0, 0, 0, 0, 0, 8'h02))
            begin errors++; $display("FAIL add_hold got %h exp %h", obs(), vec(0,0,0,0,0,8'h02)); end
        issue(8'hFF, 8'h01, 2'd0);
        checks++;
        if (obs() !== vec(1, 0, 1, 0, 0, 8'h00))
            begin errors++; $display("FAIL add_carry got %h exp %h", obs(), vec(1,0,1,0,0,8'h00)); end
    endtask

    task automatic test_sub();
        issue(8'd5, 8'd2, 2'd1);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'h03))
            begin errors++; $display("FAIL sub_5_2 got %h exp %h", obs(), vec(1,0,0,0,0,8'h03)); end
        issue(8'd2, 8'd3, 2'd1);
        checks++;
        if (obs() !== vec(1, 0, 1, 0, 0, 8'hFF))
            begin errors++; $display("FAIL sub_borrow got %h exp %h", obs(), vec(1,0,1,0,0,8'hFF)); end
    endtask

    task automatic test_mul();
        issue(8'd2, 8'd3, 2'd2);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'h06))
            begin errors++; $display("FAIL mul_2_3 got %h exp %h", obs(), vec(1,0,0,0,0,8'h06)); end
        issue(8'h20, 8'h10, 2'd2);
        checks++;
        if (obs() !== vec(1, 0, 0, 1, 0, 8'h00))
            begin errors++; $display("FAIL mul_overflow got %h exp %h", obs(), vec(1,0,0,1,0,8'h00)); end
        issue(8'd1, 8'd1, 2'd0);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'h02))
            begin errors++; $display("FAIL mul_flag_clear got %h exp %h", obs(), vec(1,0,0,0,0,8'h02)); end
    endtask

    task automatic test_div();
        int busy_cnt = 0;
        int early_valid = 0;
        issue(8'd8, 8'd2, 2'd3);
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (out_valid !== 1'b0) early_valid++;
            // Ignored request with different operands while the divider runs.
            if (i == 2) begin a = 8'd1; b = 8'd1; sel = 2'd0; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            step();
        end
        checks++;
        if (busy_cnt != 8 || early_valid != 0)
            begin errors++; $display("FAIL div_busy_len got busy=%0d early_valid=%0d exp busy=8 early_valid=0", busy_cnt, early_valid); end
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'h04))
            begin errors++; $display("FAIL div_8_2 got %h exp %h", obs(), vec(1,0,0,0,0,8'h04)); end
        step();
        checks++;
        if (obs() !== vec(0, 0, 0, 0, 0, 8'h04))
            begin errors++; $display("FAIL div_no_queue got %h exp %h", obs(), vec(0,0,0,0,0,8'h04)); end
    endtask

    task automatic test_div_zero();
        issue(8'd7, 8'd0, 2'd3);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 1, 8'hFF))
            begin errors++; $display("FAIL div_zero got %h exp %h", obs(), vec(1,0,0,0,1,8'hFF)); end
        step();
        checks++;
        if (obs() !== vec(0, 0, 0, 0, 1, 8'hFF))
            begin errors++; $display("FAIL div_zero_after got %h exp %h", obs(), vec(0,0,0,0,1,8'hFF)); end
    endtask

    task automatic test_back_to_back();
        issue(8'd2, 8'd3, 2'd1);
        issue(8'd100, 8'd10, 2'd3);
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'd10))
            begin errors++; $display("FAIL b2b_div got %h exp %h", obs(), vec(1,0,0,0,0,8'd10)); end
        issue(8'd3, 8'd4, 2'd0);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'd7))
            begin errors++; $display("FAIL b2b_add got %h exp %h", obs(), vec(1,0,0,0,0,8'd7)); end
        issue(8'd9, 8'd9, 2'd2);
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'd81))
            begin errors++; $display("FAIL b2b_mul got %h exp %h", obs(), vec(1,0,0,0,0,8'd81)); end
    endtask

    task automatic test_reset_mid_div();
        int pulses = 0;
        issue(8'd200, 8'd7, 2'd3);
        step(); step(); step();
        rst_n = 1'b0;
        step();
        checks++;
        if (obs() !== vec(0, 0, 0, 0, 0, 8'h00))
            begin errors++; $display("FAIL rst_abort got %h exp %h", obs(), vec(0,0,0,0,0,8'h00)); end
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) pulses++;
            step();
        end
        checks++;
        if (pulses != 0)
            begin errors++; $display("FAIL rst_quiet got %0d active cycles exp 0", pulses); end
        rst_n = 1'b1;
        issue(8'd200, 8'd7, 2'd3);
        checks++;
        if (busy !== 1'b1)
            begin errors++; $display("FAIL rst_first_accept got busy=%b exp 1", busy); end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (obs() !== vec(1, 0, 0, 0, 0, 8'd28))
            begin errors++; $display("FAIL div_200_7 got %h exp %h", obs(), vec(1,0,0,0,0,8'd28)); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arithmetic
`default_nettype wire

// File: doc/arithmetic.md
ARITHMETIC -- requirements
Module: arithmetic

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with both ports named as below.
REQ-002 Parameter WIDTH, default 8: operand and result width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 sel  input  2  opcode: 0 add, 1 subtract, 2 multiply, 3 divide.
REQ-008 in_valid  input  1  operands and sel valid this cycle.
REQ-009 busy  output  1  division in progress; new requests not accepted.
REQ-010 result  output  WIDTH  operation result, registered.
REQ-011 out_valid  output  1  one-cycle pulse; result and flags updated this cycle.
REQ-012 carry  output  1  add carry-out, or subtract borrow (a < b).
REQ-013 overflow  output  1  multiply product exceeds WIDTH bits.
REQ-014 div_by_zero  output  1  divide issued with b == 0.

Function
REQ-015 A request SHALL be accepted on a clk edge with in_valid=1, busy=0 and rst_n=1; in_valid while busy=1 SHALL be ignored, with no queuing.
REQ-016 Add: result = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum; latency 1 cycle; e.g. 1+1 -> 2.
REQ-017 Subtract: result = (a-b) mod 2^WIDTH, two's-complement wrap, carry = (a<b); latency 1; e.g. 5-2 -> 3, 2-3 -> 0xFF with carry=1.
REQ-018 Multiply: result = low WIDTH bits of a*b, overflow = (high WIDTH bits != 0); latency 1; e.g. 2*3 -> 6.
REQ-019 Divide: result = floor(a/b), computed by an iterative restoring divider, one quotient bit per cycle.
REQ-020 Divide timing: busy SHALL assert the cycle after acceptance for exactly WIDTH cycles, and out_valid SHALL pulse on the cycle busy deasserts; e.g. 8/2 -> 4.
REQ-021 Divide by zero: no iteration; result = all ones, div_by_zero=1, out_valid after 1 cycle, busy never asserted.
REQ-022 Flags not relevant to the executed opcode SHALL be 0 in the out_valid cycle.
REQ-023 Operands and sel SHALL be captured at acceptance; later input changes SHALL not affect an in-flight division.
REQ-024 result and flags SHALL hold their last values between out_valid pulses.
REQ-025 out_valid SHALL be high for exactly one cycle per accepted request.
REQ-026 A new request MAY be accepted in the same cycle out_valid pulses for the previous one.

Reset
REQ-027 While rst_n=0 at a clk edge: result=0, carry=0, overflow=0, div_by_zero=0, out_valid=0, busy=0, and divider state cleared.
REQ-028 Reset asserted mid-division SHALL abort it with no out_valid pulse; the first request SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-029 Package arithmetic_pkg SHALL hold the opcode enum (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3) and default WIDTH.
REQ-030 One sub-module, arithmetic_div, SHALL implement the iterative divider with start/done/busy ports; add, subtract, multiply and the output registers remain in arithmetic.

Verification
REQ-031 a=1, b=1, sel=0, one in_valid pulse -> next cycle result=2, carry=0, out_valid=1.
REQ-032 a=5, b=2, sel=1 -> result=3, carry=0; a=2, b=3, sel=1 -> result=0xFF, carry=1.
REQ-033 a=2, b=3, sel=2 -> result=6, overflow=0; a=0x20, b=0x10, sel=2 -> result=0x00, overflow=1.
REQ-034 a=8, b=2, sel=3 -> busy high for 8 cycles, then result=4 with out_valid; a second in_valid during busy is ignored.
REQ-035 a=7, b=0, sel=3 -> next cycle result=0xFF, div_by_zero=1, busy stays 0.
REQ-036 Start a=200, b=7, sel=3, drop rst_n low in cycle 4 -> no out_valid, all outputs 0; after release, a=200, b=7, sel=3 -> result=28.
